axi_info_reader: RTL and testbench

- AXI4-Lite read-only initiator: the master-side counterpart of the compiled-in info ROM slave.
- On a start pulse it reads N consecutive 32-bit words from a slave window at BASE_ADDR, one transaction at a time.
- Each returned word is forwarded on an AXI-Stream output, with TLAST on the final word.
- Used for boot-time readout of build/config info into on-chip consumers (e.g. self-check logic, debug UART framer).

---
 rtl/axi_info_reader.sv | 167 ++++++++++++++++
 tb/tb_axi_info_reader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_info_reader.sv
// rtl/axi_info_reader.sv - AXI4-Lite read-only initiator streaming N words out on AXI-Stream (option macro: AXI_INFO_READER_ABORT_ON_ERR_EN)
module axi_info_reader #(
    parameter int                    N          = 4,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                                  ap_clk,
    input  logic                                  ap_rst,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  err_idx,
    output logic                                  m_axi_ARVALID,
    input  logic                                  m_axi_ARREADY,
    output logic [ADDR_WIDTH-1:0]                 m_axi_ARADDR,
    output logic [2:0]                            m_axi_ARPROT,
    input  logic                                  m_axi_RVALID,
    output logic                                  m_axi_RREADY,
    input  logic [DATA_WIDTH-1:0]                 m_axi_RDATA,
    input  logic [1:0]                            m_axi_RRESP,
    output logic                                  m_axis_TVALID,
    input  logic                                  m_axis_TREADY,
    output logic [DATA_WIDTH-1:0]                 m_axis_TDATA,
    output logic                                  m_axis_TLAST
);

    localparam int                    IW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]         LAST_IDX   = IW'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_OUT,
        S_FIN
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [IW-1:0]           r_idx;
    logic                    r_err;
    logic [IW-1:0]           r_err_idx;
    logic [DATA_WIDTH-1:0]   r_tdata;
    logic                    r_tlast;
    logic                    w_last;
    logic                    w_bad_resp;
    logic [ADDR_WIDTH-1:0]   w_araddr;

    assign w_last     = (r_idx == LAST_IDX);
    assign w_bad_resp = (m_axi_RRESP != 2'b00);
    // Address depends only on the registered index, so it is stable across ARREADY stalls.
    assign w_araddr   = BASE_ADDR + ADDR_WIDTH'(r_idx) * WORD_BYTES;

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-decoded handshake outputs.
    always_comb begin
        w_next        = r_state;
        busy          = 1'b0;
        done          = 1'b0;
        m_axi_ARVALID = 1'b0;
        m_axi_RREADY  = 1'b0;
        m_axis_TVALID = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                busy          = 1'b1;
                m_axi_ARVALID = 1'b1;
                if (m_axi_ARREADY) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                busy         = 1'b1;
                m_axi_RREADY = 1'b1;
                if (m_axi_RVALID) begin
`ifdef AXI_INFO_READER_ABORT_ON_ERR_EN
                    w_next = w_bad_resp ? S_FIN : S_OUT;
`else
                    w_next = S_OUT;
`endif
                end
            end
            S_OUT: begin
                busy          = 1'b1;
                m_axis_TVALID = 1'b1;
                if (m_axis_TREADY) begin
                    w_next = w_last ? S_FIN : S_ADDR;
                end
            end
            S_FIN: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Word index, captured read data and first-error bookkeeping.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
            r_tdata   <= '0;
            r_tlast   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx     <= '0;
                        r_err     <= 1'b0;
                        r_err_idx <= '0;
                        r_tlast   <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (m_axi_RVALID) begin
                        r_tdata <= m_axi_RDATA;
`ifdef AXI_INFO_READER_ABORT_ON_ERR_EN
                        // A discarded word must not leave TLAST behind for the aborted stream.
                        r_tlast <= w_last && !w_bad_resp;
`else
                        r_tlast <= w_last;
`endif
                        if (w_bad_resp && !r_err) begin
                            r_err     <= 1'b1;
                            r_err_idx <= r_idx;
                        end
                    end
                end
                S_OUT: begin
                    if (m_axis_TREADY && !w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign err          = r_err;
    assign err_idx      = r_err_idx;
    assign m_axi_ARADDR = w_araddr;
    assign m_axi_ARPROT = 3'b000;
    assign m_axis_TDATA = r_tdata;
    assign m_axis_TLAST = r_tlast;

endmodule

// File: tb/tb_axi_info_reader.sv
// tb/tb_axi_info_reader.sv - directed bench for axi_info_reader with stalling slave/sink models
module tb_axi_info_reader;

    localparam int              DW    = 32;
    localparam int              AW    = 12;
    localparam logic [AW-1:0]   BASE  = 12'h100;
    localparam logic [AW-1:0]   BASE1 = 12'h040;

    logic           ap_clk = 1'b0;
    logic           ap_rst = 1'b1;
    logic           start  = 1'b0;
    logic           busy, done, err;
    logic [1:0]     err_idx;
    logic           arvalid, arready, rvalid, rready, tvalid, tready, tlast;
    logic [AW-1:0]  araddr;
    logic [2:0]     arprot;
    logic [DW-1:0]  rdata, tdata;
    logic [1:0]     rresp;

    logic           start_1 = 1'b0;
    logic           busy_1, done_1, err_1;
    logic [0:0]     err_idx_1;
    logic           arvalid_1, rready_1, tvalid_1, tlast_1;
    logic           arready_1 = 1'b1;
    logic           tready_1  = 1'b1;
    logic           rvalid_1  = 1'b0;
    logic [AW-1:0]  araddr_1;
    logic [2:0]     arprot_1;
    logic [DW-1:0]  rdata_1 = '0;
    logic [DW-1:0]  tdata_1;
    logic [1:0]     rresp_1 = 2'b00;

    int total = 0;
    int bad   = 0;
    int stall_max = 0;
    int err_word  = -1;
    bit sink_block = 1'b0;
    int done_cnt = 0;
    logic [DW-1:0] rx_data[$];
    logic          rx_last[$];
    logic [AW-1:0] ar_q[$];

    always #5 ap_clk = ~ap_clk;

    axi_info_reader #(.N(4), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start),
        .busy(busy), .done(done), .err(err), .err_idx(err_idx),
        .m_axi_ARVALID(arvalid), .m_axi_ARREADY(arready), .m_axi_ARADDR(araddr), .m_axi_ARPROT(arprot),
        .m_axi_RVALID(rvalid), .m_axi_RREADY(rready), .m_axi_RDATA(rdata), .m_axi_RRESP(rresp),
        .m_axis_TVALID(tvalid), .m_axis_TREADY(tready), .m_axis_TDATA(tdata), .m_axis_TLAST(tlast)
    );

    axi_info_reader #(.N(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE1)) dut1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start_1),
        .busy(busy_1), .done(done_1), .err(err_1), .err_idx(err_idx_1),
        .m_axi_ARVALID(arvalid_1), .m_axi_ARREADY(arready_1), .m_axi_ARADDR(araddr_1), .m_axi_ARPROT(arprot_1),
        .m_axi_RVALID(rvalid_1), .m_axi_RREADY(rready_1), .m_axi_RDATA(rdata_1), .m_axi_RRESP(rresp_1),
        .m_axis_TVALID(tvalid_1), .m_axis_TREADY(tready_1), .m_axis_TDATA(tdata_1), .m_axis_TLAST(tlast_1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // AXI-Lite slave: word w returns 0xA0+w, DECERR on err_word, random AR/R stalls.
    initial begin : slave
        bit            ar_hold = 1'b0;
        logic [AW-1:0] ar_h = '0;
        bit            r_pend = 1'b0;
        int            r_cnt = 0;
        int            ar_cnt = 0;
        int            w = 0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        forever begin
            @(negedge ap_clk);
            if (ap_rst) begin
                arready = 1'b0; rvalid = 1'b0; ar_hold = 1'b0; r_pend = 1'b0; ar_cnt = 0;
            end else begin
                if (rvalid) rvalid = 1'b0;
                if (r_pend) begin
                    if (r_cnt == 0) begin
                        chk("rready", rready, 1);
                        rvalid = 1'b1;
                        rdata  = 32'hA0 + w;
                        rresp  = (w == err_word) ? 2'b11 : 2'b00;
                        r_pend = 1'b0;
                    end else begin
                        r_cnt--;
                    end
                end
                if (arvalid) begin
                    if (ar_hold) chk("araddr_hold", araddr, ar_h);
                    else begin ar_hold = 1'b1; ar_h = araddr; end
                    arready = (ar_cnt == 0);
                    if (ar_cnt > 0) ar_cnt--;
                    if (arready) begin
                        ar_q.push_back(araddr);
                        w = int'((araddr - BASE) >> 2);
                        r_pend = 1'b1;
                        r_cnt = $urandom_range(0, stall_max);
                        ar_cnt = $urandom_range(0, stall_max);
                        ar_hold = 1'b0;
                    end
                end else begin
                    if (ar_hold) chk("arvalid_hold", arvalid, 1);
                    arready = (stall_max == 0);
                end
            end
        end
    end

    // Stream sink with random TREADY stalls; records each accepted beat.
    initial begin : sink
        bit            t_hold = 1'b0;
        logic [DW-1:0] t_d = '0;
        logic          t_l = 1'b0;
        int            t_cnt = 0;
        tready = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (ap_rst) begin
                tready = 1'b0; t_hold = 1'b0; t_cnt = 0;
            end else if (tvalid) begin
                if (t_hold) begin
                    chk("tdata_hold", tdata, t_d);
                    chk("tlast_hold", tlast, t_l);
                end else begin
                    t_hold = 1'b1; t_d = tdata; t_l = tlast;
                end
                tready = (t_cnt == 0) && !sink_block;
                if (t_cnt > 0) t_cnt--;
                if (tready) begin
                    rx_data.push_back(tdata);
                    rx_last.push_back(tlast);
                    t_hold = 1'b0;
                    t_cnt = $urandom_range(0, stall_max);
                end
            end else begin
                if (t_hold) chk("tvalid_hold", tvalid, 1);
                tready = (stall_max == 0) && !sink_block;
            end
        end
    end

    initial begin : done_mon
        forever begin
            @(negedge ap_clk);
            if (done) done_cnt++;
        end
    end

    task automatic clear_q();
        rx_data.delete();
        rx_last.delete();
        ar_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge ap_clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge ap_clk);
            cyc++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic after_done();
        @(negedge ap_clk);
        chk("done_one_cycle", done, 0);
        chk("busy_fall", busy, 0);
    endtask

    task automatic check_run(input int exp_words, input int exp_addrs);
        chk("n_words", rx_data.size(), exp_words);
        chk("n_addrs", ar_q.size(), exp_addrs);
        for (int i = 0; i < rx_data.size() && i < exp_words; i++) begin
            chk($sformatf("tdata%0d", i), rx_data[i], 32'hA0 + (i % 4));
            chk($sformatf("tlast%0d", i), rx_last[i], (i % 4) == 3);
        end
        for (int i = 0; i < ar_q.size() && i < exp_addrs; i++) begin
            chk($sformatf("araddr%0d", i), ar_q[i], 12'h100 + 4 * (i % 4));
        end
    endtask

    initial begin : main
        int cyc;
        int d0;
        int k;
        repeat (2) @(negedge ap_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_idx", err_idx, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_araddr", araddr, 12'h100);
        chk("rst_arprot", arprot, 0);
        chk("rst_rready", rready, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_araddr_1", araddr_1, 12'h040);
        ap_rst = 1'b0;
        @(negedge ap_clk);

        // Stall-free readout: 3 cycles per word, FIN on the 13th cycle.
        clear_q(); stall_max = 0; err_word = -1;
        pulse_start();
        wait_done(cyc);
        chk("latency", cyc, 13);
        after_done();
        check_run(4, 4);
        chk("err_ok", err, 0);

        // Random stalls on AR, R and T.
        clear_q(); stall_max = 5;
        pulse_start();
        wait_done(cyc);
        after_done();
        check_run(4, 4);
        chk("err_stall", err, 0);

        // DECERR on word 2.
        clear_q(); stall_max = 0; err_word = 2;
        pulse_start();
        wait_done(cyc);
        after_done();
`ifdef AXI_INFO_READER_ABORT_ON_ERR_EN
        check_run(2, 3);
`else
        check_run(4, 4);
`endif
        chk("err_set", err, 1);
        chk("err_idx", err_idx, 2);

        // start while busy is ignored; a start right after done is honoured.
        clear_q(); err_word = -1; d0 = done_cnt;
        start = 1'b1;
        @(negedge ap_clk);
        chk("err_cleared", err, 0);
        chk("busy_c1", busy, 1);
        @(negedge ap_clk);
        start = 1'b0;
        repeat (3) @(negedge ap_clk);
        start = 1'b1;
        @(negedge ap_clk);
        start = 1'b0;
        wait_done(cyc);
        after_done();
        pulse_start();
        wait_done(cyc);
        after_done();
        chk("restart_dones", done_cnt - d0, 2);
        check_run(8, 8);

        // Reset while OUT holds TVALID.
        clear_q(); d0 = done_cnt; sink_block = 1'b1;
        pulse_start();
        k = 0;
        while (!tvalid && k < 50) begin
            @(negedge ap_clk);
            k++;
        end
        chk("tvalid_reached", tvalid, 1);
        ap_rst = 1'b1;
        #1;
        chk("arst_tvalid", tvalid, 0);
        chk("arst_arvalid", arvalid, 0);
        chk("arst_rready", rready, 0);
        chk("arst_busy", busy, 0);
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0; sink_block = 1'b0;
        repeat (2) @(negedge ap_clk);
        chk("arst_no_done", done_cnt - d0, 0);
        clear_q();
        pulse_start();
        wait_done(cyc);
        after_done();
        check_run(4, 4);

        // N=1 instance, scripted handshakes.
        start_1 = 1'b1;
        @(negedge ap_clk);
        start_1 = 1'b0;
        chk("n1_arvalid", arvalid_1, 1);
        chk("n1_araddr", araddr_1, 12'h040);
        @(negedge ap_clk);
        chk("n1_rready", rready_1, 1);
        rvalid_1 = 1'b1; rdata_1 = 32'h5A5A_0001; rresp_1 = 2'b00;
        @(negedge ap_clk);
        rvalid_1 = 1'b0;
        chk("n1_tvalid", tvalid_1, 1);
        chk("n1_tdata", tdata_1, 32'h5A5A_0001);
        chk("n1_tlast", tlast_1, 1);
        @(negedge ap_clk);
        chk("n1_done", done_1, 1);
        chk("n1_tvalid_off", tvalid_1, 0);
        @(negedge ap_clk);
        chk("n1_done_off", done_1, 0);
        chk("n1_busy_off", busy_1, 0);
        chk("n1_err", err_1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
